program_sequencer: RTL
======================

# program_sequencer

Top-level execution controller for the 9-bit core. Owns the program counter and the start/done handshake with the test harness, and inserts a one-cycle stall for memory reads. It steers the next PC from the control unit's branchEnable and the branch-target LUT. The instruction ROM and branch LUT are read combinationally from its outputs. Its commit_en output gates the control unit's regWrite/memWrite/memRead, so no architectural state changes outside an active run.

## Interface
- PC_W, 10, program counter width; instruction ROM depth 2^PC_W
- CNT_W, 16, cycle counter width
- HALT_OP, 9'h07F, instruction encoding that ends a run (R-type, funct 4'b1111)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- start  in  1  level; sampled in IDLE/DONE to begin a run at PC 0
- instr  in  9  instruction from ROM at address pc (combinational, same cycle)
- mem_read  in  1  control unit memRead for current instr
- branch_en  in  1  control unit branchEnable for current instr
- branch_target  in  PC_W  LUT output for current instr's LUTIndex (instr[4:0])
- pc  out  PC_W  current instruction address (registered)
- commit_en  out  1  current instruction may write reg/mem this cycle
- busy  out  1  state is RUN or WAIT
- done  out  1  run finished (registered, held)
- cycle_count  out  CNT_W  cycles spent in RUN+WAIT for the current/last run

## Operation
- States: IDLE, RUN, WAIT, DONE. Encoding is free.
- Reset values: state=IDLE, pc=0, done=0, cycle_count=0. Combinational outputs follow: commit_en=0, busy=0.
- IDLE: commit_en=0. If start=1, go to RUN with pc=0 and cycle_count=0.
- RUN, instr==HALT_OP: commit_en=0, go to DONE, done=1, pc unchanged.
- RUN, mem_read=1: commit_en=0, go to WAIT, pc held. Branch is ignored in this cycle; M-type instructions never branch.
- RUN, otherwise: commit_en=1. If branch_en=1, pc←branch_target. Otherwise pc←pc+1, wrapping modulo 2^PC_W so that 2^PC_W−1 goes to 0.
- WAIT: commit_en=1 because load data is valid this cycle. Then pc←pc+1 (same wrap rule) and go to RUN.
- DONE: done=1, commit_en=0, pc frozen. If start=1, go to RUN with pc=0, cycle_count=0 and done=0, all on the same edge.
- start is ignored in RUN and WAIT.
- cycle_count increments by 1 on every edge where the state is RUN or WAIT. It saturates at 2^CNT_W−1 and never wraps. It holds in DONE and IDLE.
- HALT check takes priority over mem_read and branch_en.
- Reset asserted in any state, including mid-WAIT, wins over all other conditions. The next state is the reset values; no commit occurs in that cycle beyond the combinational commit_en of the pre-edge state.

## Timing
- pc, state, done and cycle_count are registered. commit_en and busy are combinational from state and instr.
- Latency from start=1 sampled to pc=0 in RUN is 1 edge.
- First instruction commits in the cycle after that edge.
- Non-memory instruction: 1 cycle.
- mem_read instruction: 2 cycles (RUN then WAIT). Commit occurs in the WAIT cycle only.
- Taken branch: 1 cycle, no bubble.
- HALT: done=1 one edge after HALT is presented in RUN. The HALT cycle itself is counted in cycle_count.
- Restart from DONE: done falls on the same edge that pc←0.

## Test plan
- Straight-line run: ROM holds 3 ALU ops then HALT_OP; pulse start. Expect pc 0,1,2,3; commit_en=1 for 3 cycles; done=1 on the 5th edge after start; cycle_count=4.
- Branches: instr at pc=2 with branch_en=1 and branch_target=7 gives pc=7 on the next edge. The same instr with branch_en=0 gives pc=3.
- Load stall: load at pc=1 with mem_read=1. Expect pc=1 for 2 cycles; commit_en 0 then 1; pc=2 afterwards; cycle_count counts both cycles.
- Wrap and saturation, with PC_W=4 and CNT_W=3: pc advances 15→0, and cycle_count sticks at 7 for a long run.
- Restart and ignore: start held high during RUN has no effect. In DONE, start=1 gives done=0 and pc=0 on the same edge, and cycle_count restarts from 0.
- Reset mid-run: assert reset in WAIT at pc=5. Next edge: state IDLE, pc=0, done=0, cycle_count=0, busy=0, commit_en=0.

Source files
------------

// File: rtl/program_sequencer_if.sv
// Harness-facing bundle for the program sequencer: start/done handshake,
// current-instruction decode inputs from the ROM/LUT/control unit, and status.
interface program_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [8:0]       instr;
    logic             mem_read;
    logic             branch_en;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  pc;
    logic             commit_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, instr, mem_read, branch_en, branch_target,
        input  pc, commit_en, busy, done, cycle_count
    );

    modport slave (
        input  start, instr, mem_read, branch_en, branch_target,
        output pc, commit_en, busy, done, cycle_count
    );
endinterface

// File: rtl/program_sequencer.sv
// Execution controller for the 9-bit core: owns the PC, the start/done handshake,
// the one-cycle load stall and the run cycle counter.
module program_sequencer #(
    parameter int         PC_W    = 10,
    parameter int         CNT_W   = 16,
    parameter logic [8:0] HALT_OP = 9'h07F
) (
    input  logic clk,
    input  logic reset,
    program_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [PC_W-1:0]  pc_q, pc_nxt;
    logic             done_q, done_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             is_halt;
    logic             in_run;
    logic             commit;

    assign is_halt = (bus.instr == HALT_OP);
    assign in_run  = (state == RUN) || (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            done_q <= done_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // The counter covers every RUN/WAIT cycle, including the HALT cycle, and
    // sticks at all-ones rather than wrapping.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        done_nxt  = done_q;
        cnt_nxt   = cnt_q;
        commit    = 1'b0;

        if (in_run && !(&cnt_q)) begin
            cnt_nxt = cnt_q + 1'b1;
        end

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b0;
                end
            end
            RUN: begin
                if (is_halt) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (bus.mem_read) begin
                    state_nxt = WAIT;
                end else begin
                    commit = 1'b1;
                    if (bus.branch_en) begin
                        pc_nxt = bus.branch_target;
                    end else begin
                        pc_nxt = pc_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                commit    = 1'b1;
                pc_nxt    = pc_q + 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.pc          = pc_q;
    assign bus.commit_en   = commit;
    assign bus.busy        = in_run;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule
